rrt_sample_gen: RTL and testbench
=================================

Name: rrt_sample_gen

Overview:
Consumes the 64-bit xorshift PRNG stream and produces bounded 2-D random sample points for the RRT tree-extension datapath. Drives the PRNG's advance-enable, slices the returned word into x/y/bias fields and scales each field into a configured workspace window. Emits one point per valid/ready handshake to the nearest-neighbour search stage downstream.

Parameters:
COORD_W, 16, coordinate width in bits; legal range 1..24.
CNT_W, 32, width of the sample counter.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
en  in  1  run request; level-sensitive
rand_en  out  1  advance pulse to the PRNG `en` input
rand_in  in  64  PRNG `out`, updated on the edge after rand_en
x_min  in  COORD_W  window x origin
x_span  in  COORD_W  window x extent
y_min  in  COORD_W  window y origin
y_span  in  COORD_W  window y extent
goal_x  in  COORD_W  goal x; used only with the optional feature
goal_y  in  COORD_W  goal y; used only with the optional feature
bias_thresh  in  16  goal-bias threshold; used only with the optional feature
out_valid  out  1  sample available
out_ready  in  1  downstream accepts
out_x  out  COORD_W  sample x
out_y  out  COORD_W  sample y
out_is_goal  out  1  sample is the goal point
sample_count  out  CNT_W  completed handshakes; wraps at 2^CNT_W

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; rand_en=0, out_valid=0, out_x=0, out_y=0, out_is_goal=0, sample_count=0; shadow config regs cleared. rst has priority over every other event, including mid-sample; a partially built sample is discarded.
- Shadow config: x_min, x_span, y_min, y_span, goal_x, goal_y and bias_thresh are latched on every transition into GEN. Port changes at any other time have no effect on the sample in flight.
- States and transitions:
  - IDLE: if en=1 -> GEN; otherwise stay.
  - GEN: rand_en=1 for exactly this one cycle -> CAPT. rand_en is 0 in every other state.
  - CAPT: rand_in now holds the freshly advanced word; register the fields and products -> SCALE.
    - x_raw = rand_in[63 -: COORD_W]
    - y_raw = rand_in[39 -: COORD_W]
    - bias = rand_in[15:0]
    - px = x_raw*x_span and py = y_raw*y_span, each full 2*COORD_W bits.
  - SCALE: load the output registers -> VALID.
    - out_x = x_min + px[2*COORD_W-1:COORD_W]
    - out_y = y_min + py[2*COORD_W-1:COORD_W]
    - The add wraps mod 2^COORD_W; keeping the window in range is the configuration's responsibility.
    - span=0 gives out = min. Otherwise out lies in [min, min+span-1].
  - VALID: out_valid=1 with outputs held stable until out_ready=1. At the handshake edge: sample_count+1, out_valid drops, then en=1 -> GEN, en=0 -> IDLE.
- Latency and throughput: GEN to out_valid is 3 cycles. With out_ready held high, one sample per 4 cycles.
- The PRNG seed word itself is never consumed; the first sample uses the first advanced value.
- en deasserted outside IDLE: the current sample completes and holds in VALID until accepted, then the block goes to IDLE. It does not abort.
- out_valid never deasserts without a handshake, except on rst.
- out_ready while out_valid=0 is ignored.

Optional Feature:
RRT_SAMPLE_GOAL_BIAS_EN
- Defined: in SCALE, if bias < bias_thresh (unsigned), out_x=goal_x, out_y=goal_y and out_is_goal=1; otherwise the normal scaled point with out_is_goal=0. Goal probability is bias_thresh/65536. bias_thresh=0 never selects the goal.
- Undefined: goal_x, goal_y and bias_thresh are ignored; out_is_goal is constant 0; no comparator is synthesised.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, en=0 for 10 cycles -> rand_en, out_valid and sample_count stay 0 throughout.
- Scaling: x_min=100, x_span=1000, y_min=0, y_span=400, bench drives rand_in=0x8000_0040_0000_0000 the cycle after rand_en -> out_valid 3 cycles after rand_en, out_x=600, out_y=100, out_is_goal=0.
- Backpressure: hold out_ready=0 for 20 cycles in VALID, toggle rand_in and x_min -> outputs unchanged, no further rand_en pulses. Release out_ready -> sample_count=1.
- Streaming and en drop: out_ready=1, en=1 for 3 samples then en=0 while in CAPT -> exactly 4 rand_en pulses spaced 4 cycles apart, 4th sample still delivered, then IDLE with sample_count=4.
- Reset mid-sample: assert rst during SCALE -> next cycle out_valid=0 and state IDLE; after release with en=1, rand_en fires within 2 cycles.
- Goal bias (macro defined): bias_thresh=0x0020, goal=(7,9), rand_in low 16 bits=0x0010 -> (7,9) with out_is_goal=1. Low bits=0x0020 -> scaled point with out_is_goal=0. Macro undefined, same stimulus -> out_is_goal=0 both times.

Source files
------------

// File: rtl/rrt_sample_gen.sv
// RRT sample generator: advances an external xorshift PRNG, scales x/y fields into a window.
// Optional goal bias enabled by defining RRT_SAMPLE_GOAL_BIAS_EN.
module rrt_sample_gen #(
    parameter int COORD_W = 16,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic               rand_en,
    input  logic [63:0]        rand_in,
    input  logic [COORD_W-1:0] x_min,
    input  logic [COORD_W-1:0] x_span,
    input  logic [COORD_W-1:0] y_min,
    input  logic [COORD_W-1:0] y_span,
    input  logic [COORD_W-1:0] goal_x,
    input  logic [COORD_W-1:0] goal_y,
    input  logic [15:0]        bias_thresh,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_is_goal,
    output logic [CNT_W-1:0]   sample_count
);

    typedef enum logic [2:0] {IDLE, GEN, CAPT, SCALE, VALID} state_t;

    state_t state, state_nxt;
    logic   hs;

    logic [COORD_W-1:0]   sh_x_min, sh_x_span, sh_y_min, sh_y_span;
    logic [2*COORD_W-1:0] px_p1, py_p1;

    function automatic logic [2*COORD_W-1:0] mul_full(input logic [COORD_W-1:0] a,
                                                      input logic [COORD_W-1:0] b);
        return {{COORD_W{1'b0}}, a} * {{COORD_W{1'b0}}, b};
    endfunction

    // Upper half of the product is the fraction of span; add wraps mod 2^COORD_W.
    function automatic logic [COORD_W-1:0] scale_coord(input logic [COORD_W-1:0]   base,
                                                       input logic [2*COORD_W-1:0] prod);
        return base + prod[2*COORD_W-1:COORD_W];
    endfunction

    assign hs = (state == VALID) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rand_en   = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:  if (en) state_nxt = GEN;
            GEN: begin
                rand_en   = 1'b1;
                state_nxt = CAPT;
            end
            CAPT:  state_nxt = SCALE;
            SCALE: state_nxt = VALID;
            VALID: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = en ? GEN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef RRT_SAMPLE_GOAL_BIAS_EN
    logic [COORD_W-1:0] sh_goal_x, sh_goal_y;
    logic [15:0]        sh_bias_thresh, bias_p1;
    logic               is_goal_p2;
    logic               unused_in;

    assign unused_in   = ^rand_in;
    assign out_is_goal = is_goal_p2;
`else
    logic unused_in;

    assign unused_in   = ^{rand_in, goal_x, goal_y, bias_thresh};
    assign out_is_goal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_x_min     <= '0;
            sh_x_span    <= '0;
            sh_y_min     <= '0;
            sh_y_span    <= '0;
            px_p1        <= '0;
            py_p1        <= '0;
            out_x        <= '0;
            out_y        <= '0;
            sample_count <= '0;
`ifdef RRT_SAMPLE_GOAL_BIAS_EN
            sh_goal_x      <= '0;
            sh_goal_y      <= '0;
            sh_bias_thresh <= '0;
            bias_p1        <= '0;
            is_goal_p2     <= 1'b0;
`endif
        end else begin
            if (state_nxt == GEN) begin
                sh_x_min  <= x_min;
                sh_x_span <= x_span;
                sh_y_min  <= y_min;
                sh_y_span <= y_span;
`ifdef RRT_SAMPLE_GOAL_BIAS_EN
                sh_goal_x      <= goal_x;
                sh_goal_y      <= goal_y;
                sh_bias_thresh <= bias_thresh;
`endif
            end

            // p1: capture the freshly advanced word as raw fields times span
            if (state == CAPT) begin
                px_p1 <= mul_full(rand_in[63 -: COORD_W], sh_x_span);
                py_p1 <= mul_full(rand_in[39 -: COORD_W], sh_y_span);
`ifdef RRT_SAMPLE_GOAL_BIAS_EN
                bias_p1 <= rand_in[15:0];
`endif
            end

            // p2: offset into the window (or substitute the goal) and hold for the handshake
            if (state == SCALE) begin
`ifdef RRT_SAMPLE_GOAL_BIAS_EN
                if (bias_p1 < sh_bias_thresh) begin
                    out_x      <= sh_goal_x;
                    out_y      <= sh_goal_y;
                    is_goal_p2 <= 1'b1;
                end else begin
                    out_x      <= scale_coord(sh_x_min, px_p1);
                    out_y      <= scale_coord(sh_y_min, py_p1);
                    is_goal_p2 <= 1'b0;
                end
`else
                out_x <= scale_coord(sh_x_min, px_p1);
                out_y <= scale_coord(sh_y_min, py_p1);
`endif
            end

            if (hs) sample_count <= sample_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rrt_sample_gen.sv
// Scoreboard bench for rrt_sample_gen: bench plays the PRNG, predicts each point from the word.
module tb_rrt_sample_gen;

    localparam int W  = 16;
    localparam int CW = 32;
`ifdef RRT_SAMPLE_GOAL_BIAS_EN
    localparam bit GOAL_ON = 1'b1;
`else
    localparam bit GOAL_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, en, rand_en, out_valid, out_ready, out_is_goal;
    logic [63:0]   rand_in;
    logic [W-1:0]  x_min, x_span, y_min, y_span, goal_x, goal_y, out_x, out_y;
    logic [15:0]   bias_thresh;
    logic [CW-1:0] sample_count;

    typedef struct {
        logic [63:0] xmin, xspan, ymin, yspan, gx, gy, thr;
    } cfg_t;

    typedef struct {
        logic [W-1:0] x, y;
        logic         g;
    } exp_t;

    int          checks   = 0;
    int          failures = 0;
    exp_t        sb[$];
    logic [63:0] forced[$];
    longint      gen_cyc[$];
    longint      cyc = 0;

    rrt_sample_gen #(.COORD_W(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .rand_en(rand_en), .rand_in(rand_in),
        .x_min(x_min), .x_span(x_span), .y_min(y_min), .y_span(y_span),
        .goal_x(goal_x), .goal_y(goal_y), .bias_thresh(bias_thresh),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
        .out_is_goal(out_is_goal), .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic cfg_t cur_cfg();
        cfg_t c;
        c.xmin = 64'(x_min);  c.xspan = 64'(x_span);
        c.ymin = 64'(y_min);  c.yspan = 64'(y_span);
        c.gx   = 64'(goal_x); c.gy    = 64'(goal_y);
        c.thr  = 64'(bias_thresh);
        return c;
    endfunction

    // A point is min + floor(raw * span / 2^W), taken mod 2^W; goal wins when bias < threshold.
    function automatic exp_t model(input logic [63:0] w, input cfg_t c);
        exp_t        e;
        logic [63:0] xr, yr, bias;
        xr   = w >> (64 - W);
        yr   = (w >> (40 - W)) & ((64'd1 << W) - 1);
        bias = w & 64'hFFFF;
        e.x  = W'(c.xmin + ((xr * c.xspan) >> W));
        e.y  = W'(c.ymin + ((yr * c.yspan) >> W));
        e.g  = 1'b0;
        if (GOAL_ON && bias < c.thr) begin
            e.x = W'(c.gx);
            e.y = W'(c.gy);
            e.g = 1'b1;
        end
        return e;
    endfunction

    task automatic wait_valid(input string name, input int maxc);
        bit seen = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        check(name, 64'(seen), 64'd1);
    endtask

    // PRNG stand-in: a new word appears on the edge after rand_en, and its prediction is queued.
    initial begin
        cfg_t        prev, use_cfg;
        bit          pend;
        logic [63:0] w;
        prev = cur_cfg();
        forever begin
            @(negedge clk);
            pend    = rand_en;
            use_cfg = prev;
            prev    = cur_cfg();
            @(posedge clk);
            #1;
            if (pend) begin
                if (forced.size() > 0) w = forced.pop_front();
                else                   w = {$urandom, $urandom};
                rand_in = w;
                sb.push_back(model(w, use_cfg));
            end
        end
    end

    // Monitor: pops a prediction at every handshake, checks latency, hold-stability and count.
    initial begin
        logic         pv = 0, phs = 0, pre = 0, hg = 0;
        logic [W-1:0] hx = '0, hy = '0;
        longint       last_gen = -100;
        int           expc = 0;
        exp_t         e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                sb.delete();
                expc = 0; pv = 0; phs = 0; pre = 0; last_gen = -100;
                continue;
            end
            if (rand_en) begin
                check("rand_en_single", 64'({pre, rand_en}), 64'd1);
                gen_cyc.push_back(cyc);
                last_gen = cyc;
            end
            if (out_valid && !pv) check("latency", 64'(cyc - last_gen), 64'd3);
            if (pv && !phs) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_x", 64'(out_x), 64'(hx));
                check("hold_y", 64'(out_y), 64'(hy));
                check("hold_goal", 64'(out_is_goal), 64'(hg));
            end
            check("sample_count", 64'(sample_count), 64'(expc));
            phs = out_valid && out_ready;
            if (phs) begin
                check("sb_depth", 64'(sb.size()), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("out_x", 64'(out_x), 64'(e.x));
                    check("out_y", 64'(out_y), 64'(e.y));
                    check("out_is_goal", 64'(out_is_goal), 64'(e.g));
                end
                expc++;
            end
            pv = out_valid; hx = out_x; hy = out_y; hg = out_is_goal; pre = rand_en;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        rst = 1; en = 0; out_ready = 0; rand_in = 64'h0123_4567_89AB_CDEF;
        x_min = 0; x_span = 0; y_min = 0; y_span = 0;
        goal_x = 0; goal_y = 0; bias_thresh = 0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1 rst = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_rand_en", 64'(rand_en), 64'd0);
            check("idle_valid", 64'(out_valid), 64'd0);
            check("idle_count", 64'(sample_count), 64'd0);
        end

        // Scaling of a known word
        @(posedge clk);
        #1 x_min = 100; x_span = 1000; y_min = 0; y_span = 400;
        forced.push_back(64'h8000_0040_0000_0000);
        en = 1;
        wait_valid("scale_valid", 10);
        check("scale_x", 64'(out_x), 64'd600);
        check("scale_y", 64'(out_y), 64'd100);
        check("scale_goal", 64'(out_is_goal), 64'd0);

        // Backpressure: port and PRNG changes must not disturb the held sample
        @(posedge clk);
        #1 en = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 rand_in = {$urandom, $urandom};
            x_min = W'($urandom);
            @(negedge clk);
            check("bp_x", 64'(out_x), 64'd600);
            check("bp_y", 64'(out_y), 64'd100);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_rand_en", 64'(rand_en), 64'd0);
        end
        @(posedge clk);
        #1 x_min = 100; out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        @(negedge clk);
        check("bp_count", 64'(sample_count), 64'd1);
        check("bp_drop", 64'(out_valid), 64'd0);

        // Streaming, en dropped during CAPT of the 4th sample
        @(posedge clk);
        #1 rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        gen_cyc.delete();
        x_min = W'($urandom_range(0, 2000)); x_span = W'($urandom);
        y_min = W'($urandom_range(0, 2000)); y_span = W'($urandom);
        out_ready = 1; en = 1;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (rand_en) n++;
        end
        check("stream_gen4", 64'(n), 64'd4);
        @(posedge clk);
        #1 en = 0;
        repeat (12) @(negedge clk);
        check("stream_pulses", 64'(gen_cyc.size()), 64'd4);
        for (int i = 1; i < gen_cyc.size(); i++)
            check("stream_spacing", 64'(gen_cyc[i] - gen_cyc[i-1]), 64'd4);
        check("stream_count", 64'(sample_count), 64'd4);
        check("stream_idle_valid", 64'(out_valid), 64'd0);
        check("stream_idle_gen", 64'(rand_en), 64'd0);

        // Reset during SCALE
        @(posedge clk);
        #1 out_ready = 0; en = 1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rand_en) begin
                seen = 1;
                break;
            end
        end
        check("mid_gen", 64'(seen), 64'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("mid_valid", 64'(out_valid), 64'd0);
        check("mid_idle", 64'(rand_en), 64'd0);
        check("mid_count", 64'(sample_count), 64'd0);
        seen = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (rand_en) begin
                seen = 1;
                break;
            end
        end
        check("mid_restart", 64'(seen), 64'd1);
        wait_valid("mid_valid2", 10);
        @(posedge clk);
        #1 en = 0; out_ready = 1;
        repeat (6) @(posedge clk);

        // Goal bias: threshold 0x20, bias 0x10 then 0x20
        #1 x_min = 100; x_span = 1000; y_min = 5; y_span = 400;
        goal_x = 7; goal_y = 9; bias_thresh = 16'h0020;
        forced.push_back(64'h4000_0000_2000_0010);
        forced.push_back(64'h4000_0000_2000_0020);
        en = 1;
        wait_valid("goal1_valid", 10);
        check("goal1_flag", 64'(out_is_goal), 64'(GOAL_ON));
        check("goal1_x", 64'(out_x), GOAL_ON ? 64'd7 : 64'd350);
        check("goal1_y", 64'(out_y), GOAL_ON ? 64'd9 : 64'd5);
        wait_valid("goal2_valid", 10);
        check("goal2_flag", 64'(out_is_goal), 64'd0);
        check("goal2_x", 64'(out_x), 64'd350);
        check("goal2_y", 64'(out_y), 64'd5);
        @(posedge clk);
        #1 en = 0;
        repeat (8) @(posedge clk);

        // Randomized run: random en/ready and config churn, including mid-sample changes
        for (int i = 0; i < 400; i++) begin
            #1;
            en        = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 7) == 0) begin
                x_min  = W'($urandom);
                x_span = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
                y_min  = W'($urandom);
                y_span = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
                goal_x = W'($urandom);
                goal_y = W'($urandom);
                bias_thresh = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            end
            @(posedge clk);
        end
        #1 en = 0; out_ready = 1;
        repeat (10) @(negedge clk);
        check("drain_valid", 64'(out_valid), 64'd0);
        check("drain_sb", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
